mem_bus_controller: RTL

- Initiator side of the 8-bit system memory bus. Drives address_bus, rd_en and wr_en, and the active-low chip enables rom_enable and ram_enable. Drives or releases the shared tri-state data_bus.
- Serves two CPU-side requestors: the instruction-fetch stage (read only) and the MEM stage (read/write).
- Arbitrates between them and sequences each access as SETUP / ACCESS (with wait states) / DONE.
- Returns read data on a one-cycle ack.

---
 rtl/mem_bus_pkg.sv | 35 +++
 rtl/mem_bus_if.sv | 47 ++++
 rtl/mem_bus_arbiter.sv | 56 +++++
 rtl/mem_bus_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared types and constants for the 8-bit system memory bus controller:
//   - DATA_W / ADDR_W  : bus widths
//   - ROM_LIMIT_DEFAULT: default highest ROM address (ROM below, RAM above)
//   - state_t          : access sequencer states
//   - port_t           : requestor identifiers (fetch / data)
//   - is_rom()         : address decode helper
// -----------------------------------------------------------------------------
package mem_bus_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;

    localparam logic [ADDR_W-1:0] ROM_LIMIT_DEFAULT = 16'h7FFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

    // ROM occupies 0x0000..limit inclusive; everything above is RAM.
    function automatic logic is_rom(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] limit);
        return (addr <= limit);
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// -----------------------------------------------------------------------------
// mem_bus_if
// Groups the CPU-side request/ack handshakes and the memory-side strobes of
// the bus controller. The shared tri-state data bus is kept as a plain inout
// on the controller so the bidirectional net is resolved at a module port.
//   CPU side   : if_req/if_addr/if_ack/if_rdata, d_req/d_we/d_addr/d_wdata/
//                d_ack/d_rdata/d_err
//   Memory side: address_bus, rd_en, wr_en, rom_enable (low), ram_enable (low)
// Modports:
//   master : the controller's view (drives acks and memory strobes)
//   slave  : the environment's view (requestors plus memory devices)
// -----------------------------------------------------------------------------
interface mem_bus_if;
    import mem_bus_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] address_bus;
    logic              rd_en;
    logic              wr_en;
    logic              rom_enable;
    logic              ram_enable;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output if_ack, if_rdata, d_ack, d_rdata, d_err,
        output address_bus, rd_en, wr_en, rom_enable, ram_enable
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  if_ack, if_rdata, d_ack, d_rdata, d_err,
        input  address_bus, rd_en, wr_en, rom_enable, ram_enable
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Two-requestor alternating-priority arbiter. When both ports request, the
// port that was not granted last time wins; a lone requester always wins.
// A grant is only produced while the sequencer is idle.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   idle         : sequencer is in IDLE and may accept a new access
//   if_req       : fetch request
//   d_req        : data request
//   grant_valid  : a port is granted this cycle
//   grant_port   : which port is granted (valid with grant_valid)
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  idle,
    input  logic  if_req,
    input  logic  d_req,
    output logic  grant_valid,
    output port_t grant_port
);

    port_t last_q;
    port_t last_d;

    // History starts as "data served last" so the first tie goes to fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_D;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_port  = PORT_IF;
        if (idle) begin
            if (if_req && d_req) begin
                grant_valid = 1'b1;
                grant_port  = (last_q == PORT_IF) ? PORT_D : PORT_IF;
            end else if (if_req) begin
                grant_valid = 1'b1;
                grant_port  = PORT_IF;
            end else if (d_req) begin
                grant_valid = 1'b1;
                grant_port  = PORT_D;
            end
        end
        last_d = grant_valid ? grant_port : last_q;
    end

endmodule

// File: rtl/mem_bus_controller.sv
// -----------------------------------------------------------------------------
// mem_bus_controller
// Initiator side of the 8-bit system memory bus. Serves the instruction fetch
// port (read only) and the MEM-stage data port (read/write), sequencing each
// access as SETUP -> ACCESS (1 + WAIT_STATES cycles) -> DONE, with a one-cycle
// ack in DONE. ROM writes may be rejected with d_err when SIM_ROM_WRITE=0.
// Parameters:
//   WAIT_STATES   : extra ACCESS cycles beyond the first (0..7)
//   ROM_LIMIT     : highest ROM address; RAM is ROM_LIMIT+1..0xFFFF
//   SIM_ROM_WRITE : 1 lets bus writes reach ROM, 0 rejects them
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : mem_bus_if master modport (requests, acks, memory strobes)
//   data_bus   : shared tri-state data bus, driven only for write SETUP/ACCESS
//   busy       : high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module mem_bus_controller
    import mem_bus_pkg::*;
#(
    parameter int unsigned       WAIT_STATES   = 1,
    parameter logic [ADDR_W-1:0] ROM_LIMIT     = ROM_LIMIT_DEFAULT,
    parameter bit                SIM_ROM_WRITE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_if.master         bus,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              busy
);

    localparam logic [2:0] WAIT_CNT_INIT = 3'(WAIT_STATES);

    state_t            state_q,    state_d;
    port_t             port_q,     port_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              rom_sel_q,  rom_sel_d;
    logic              err_q,      err_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;

    logic              grant_valid;
    port_t             grant_port;
    logic [ADDR_W-1:0] grant_addr;
    logic              grant_we;
    logic              grant_rom;

    logic              rom_enable_n;
    logic              ram_enable_n;
    logic              rd_strobe;
    logic              wr_strobe;
    logic              bus_drive;
    logic              if_ack_o;
    logic              d_ack_o;
    logic              d_err_o;

    mem_bus_arbiter u_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .idle        (state_q == IDLE),
        .if_req      (bus.if_req),
        .d_req       (bus.d_req),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // State register: an async reset returns to IDLE at once, so any access
    // in flight is dropped and all strobes/enables deassert immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            port_q     <= PORT_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rom_sel_q  <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rom_sel_q  <= rom_sel_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next-state logic. The request is captured at grant so later changes on
    // the requestor side cannot disturb an access already under way.
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rom_sel_d  = rom_sel_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        grant_addr = (grant_port == PORT_D) ? bus.d_addr : bus.if_addr;
        grant_we   = (grant_port == PORT_D) && bus.d_we;
        grant_rom  = is_rom(grant_addr, ROM_LIMIT);

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    port_d    = grant_port;
                    addr_d    = grant_addr;
                    we_d      = grant_we;
                    wdata_d   = bus.d_wdata;
                    rom_sel_d = grant_rom;
                    // A rejected ROM write skips the bus cycle entirely.
                    err_d     = grant_we && grant_rom && !SIM_ROM_WRITE;
                    state_d   = err_d ? DONE : SETUP;
                end
            end
            SETUP: begin
                wait_cnt_d = WAIT_CNT_INIT;
                state_d    = ACCESS;
            end
            ACCESS: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = DONE;
                    // Read data is captured on the edge that ends ACCESS.
                    if (!we_q) begin
                        if (port_q == PORT_IF) begin
                            if_rdata_d = data_bus;
                        end else begin
                            d_rdata_d = data_bus;
                        end
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: enables are only active in SETUP/ACCESS, and exactly one
    // of them follows the latched ROM/RAM decode.
    always_comb begin
        rom_enable_n = 1'b1;
        ram_enable_n = 1'b1;
        rd_strobe    = 1'b0;
        wr_strobe    = 1'b0;
        bus_drive    = 1'b0;
        if_ack_o     = 1'b0;
        d_ack_o      = 1'b0;
        d_err_o      = 1'b0;
        unique case (state_q)
            SETUP: begin
                rom_enable_n = !rom_sel_q;
                ram_enable_n = rom_sel_q;
                bus_drive    = we_q;
            end
            ACCESS: begin
                rom_enable_n = !rom_sel_q;
                ram_enable_n = rom_sel_q;
                rd_strobe    = !we_q;
                wr_strobe    = we_q;
                bus_drive    = we_q;
            end
            DONE: begin
                if_ack_o = (port_q == PORT_IF);
                d_ack_o  = (port_q == PORT_D);
                d_err_o  = (port_q == PORT_D) && err_q;
            end
            default: begin
            end
        endcase
    end

    assign data_bus        = bus_drive ? wdata_q : {DATA_W{1'bz}};
    assign bus.address_bus = addr_q;
    assign bus.rd_en       = rd_strobe;
    assign bus.wr_en       = wr_strobe;
    assign bus.rom_enable  = rom_enable_n;
    assign bus.ram_enable  = ram_enable_n;
    assign bus.if_ack      = if_ack_o;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.d_ack       = d_ack_o;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.d_err       = d_err_o;
    assign busy            = (state_q != IDLE);

endmodule
